// File: rtl/ram_pkg.sv
// ----------------------------------------------------------------------------
// ram_pkg
// Shared definitions for the simple dual-port byte-enable RAM.
//   - collision-mode encoding (WRITEFIRST parameter values)
//   - clear-FSM state encoding
//   - parameter range checks used at elaboration time
// No ports: package only.
// ----------------------------------------------------------------------------
package ram_pkg;

   // Collision behaviour when port B reads the word port A writes this cycle.
   localparam int COLL_READ_OLD = 0;  // port B sees the pre-write word
   localparam int COLL_READ_NEW = 1;  // port B sees the byte-merged word

   // Clear FSM states.
   localparam logic [0:0] CLR_ST_CLEAR = 1'b0;
   localparam logic [0:0] CLR_ST_READY = 1'b1;

   // Supported read latencies.
   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 2;

   function automatic bit rd_latency_ok(input int lat);
      return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
   endfunction

   function automatic bit data_width_ok(input int width);
      return (width >= 8) && ((width % 8) == 0);
   endfunction

   function automatic bit coll_mode_ok(input int mode);
      return (mode == COLL_READ_OLD) || (mode == COLL_READ_NEW);
   endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// ----------------------------------------------------------------------------
// ram_rd_pipe
// Read output pipeline for one read port. A request sampled on a clock edge
// carries the word read that cycle; it leaves the last stage LATENCY edges
// after the request edge minus one, i.e. valid_o is high in the cycle that
// follows the request for LATENCY=1 and one cycle later for LATENCY=2.
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-high reset; flushes every stage
//   req_i    accepted read this cycle (one result per request)
//   data_i   word read from the array this cycle
//   data_o   read data; holds its last value between results
//   valid_o  one-cycle pulse per result
// Protocol: there is no back-pressure. Every cycle with req_i=1 produces
// exactly one valid_o pulse, in order, unless a reset intervenes.
// ----------------------------------------------------------------------------
module ram_rd_pipe #(
   parameter int DW      = 32,
   parameter int LATENCY = 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          req_i,
   input  logic [DW-1:0] data_i,
   output logic [DW-1:0] data_o,
   output logic          valid_o
);

   logic          vld_q [LATENCY];
   logic [DW-1:0] dat_q [LATENCY];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < LATENCY; i++) begin
            vld_q[i] <= 1'b0;
            dat_q[i] <= '0;
         end
      end else begin
         vld_q[0] <= req_i;
         if (req_i) begin
            dat_q[0] <= data_i;
         end
         // Data only moves with a valid token so the last stage holds its
         // value while no new result is produced.
         for (int i = 1; i < LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            if (vld_q[i-1]) begin
               dat_q[i] <= dat_q[i-1];
            end
         end
      end
   end

   assign data_o  = dat_q[LATENCY-1];
   assign valid_o = vld_q[LATENCY-1];

endmodule

// File: rtl/ram_sdp_be.sv
// ----------------------------------------------------------------------------
// ram_sdp_be
// Simple dual-port RAM: port A read/write with per-byte write mask, port B
// read only, single clock, optional zero-fill after reset.
// Ports:
//   RamClk            clock
//   RamReset          synchronous active-high reset
//   InitBusy          clear sequence in progress (also high during reset)
//   PortAEnable       port A access request
//   PortAWriteEnable  1 = write, 0 = read
//   PortAAddr         port A address
//   PortADataIn       port A write data
//   PortAByteEnable   port A per-byte write mask
//   PortADataOut      port A read data (holds between results)
//   PortAValid        port A read data valid (one pulse per read)
//   PortBEnable       port B read request
//   PortBAddr         port B address
//   PortBDataOut      port B read data (holds between results)
//   PortBValid        port B read data valid (one pulse per read)
// Requests are accepted only when Enable=1, InitBusy=0 and RamReset=0;
// anything else is dropped without a response.
// ----------------------------------------------------------------------------
module ram_sdp_be
   import ram_pkg::*;
#(
   parameter int DATAWIDTH   = 32,
   parameter int ADDRWIDTH   = 10,
   parameter int READLATENCY = 1,
   parameter int WRITEFIRST  = 0,
   parameter int INITCLEAR   = 1
) (
   input  logic                   RamClk,
   input  logic                   RamReset,
   output logic                   InitBusy,
   input  logic                   PortAEnable,
   input  logic                   PortAWriteEnable,
   input  logic [ADDRWIDTH-1:0]   PortAAddr,
   input  logic [DATAWIDTH-1:0]   PortADataIn,
   input  logic [DATAWIDTH/8-1:0] PortAByteEnable,
   output logic [DATAWIDTH-1:0]   PortADataOut,
   output logic                   PortAValid,
   input  logic                   PortBEnable,
   input  logic [ADDRWIDTH-1:0]   PortBAddr,
   output logic [DATAWIDTH-1:0]   PortBDataOut,
   output logic                   PortBValid
);

   localparam int MEMDEPTH = 2**ADDRWIDTH;
   localparam int NBYTES   = DATAWIDTH / 8;

   // Elaboration-time parameter checks.
   if (!rd_latency_ok(READLATENCY)) begin : g_bad_latency
      $error("ram_sdp_be: READLATENCY must be 1 or 2");
   end
   if (!data_width_ok(DATAWIDTH)) begin : g_bad_width
      $error("ram_sdp_be: DATAWIDTH must be a non-zero multiple of 8");
   end
   if (!coll_mode_ok(WRITEFIRST)) begin : g_bad_coll
      $error("ram_sdp_be: WRITEFIRST must be 0 or 1");
   end

   logic [DATAWIDTH-1:0] mem_q [MEMDEPTH];

   logic                 clr_we;
   logic [ADDRWIDTH-1:0] clr_addr;

   // ---------------------------------------------------------------------
   // Clear FSM: CLEAR writes one zero word per cycle from address 0 up to
   // MEMDEPTH-1, then parks in READY until the next reset.
   // ---------------------------------------------------------------------
   if (INITCLEAR != 0) begin : g_clear
      logic [0:0]           clr_state_q, clr_state_d;
      logic [ADDRWIDTH-1:0] clr_cnt_q, clr_cnt_d;

      always_comb begin
         clr_state_d = clr_state_q;
         clr_cnt_d   = clr_cnt_q;
         if (clr_state_q == CLR_ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == ADDRWIDTH'(MEMDEPTH - 1)) begin
               clr_state_d = CLR_ST_READY;
            end
         end
      end

      always_ff @(posedge RamClk) begin
         if (RamReset) begin
            clr_state_q <= CLR_ST_CLEAR;
            clr_cnt_q   <= '0;
         end else begin
            clr_state_q <= clr_state_d;
            clr_cnt_q   <= clr_cnt_d;
         end
      end

      // Reset itself counts as busy so no request slips in while the
      // counter is being rewound.
      assign InitBusy = RamReset | (clr_state_q == CLR_ST_CLEAR);
      assign clr_we   = ~RamReset & (clr_state_q == CLR_ST_CLEAR);
      assign clr_addr = clr_cnt_q;
   end else begin : g_no_clear
      assign InitBusy = 1'b0;
      assign clr_we   = 1'b0;
      assign clr_addr = '0;
   end

   // ---------------------------------------------------------------------
   // Request qualification
   // ---------------------------------------------------------------------
   logic acc_ok;
   logic a_wr;
   logic a_rd;
   logic b_rd;

   assign acc_ok = ~RamReset & ~InitBusy;
   assign a_wr   = acc_ok & PortAEnable & PortAWriteEnable;
   assign a_rd   = acc_ok & PortAEnable & ~PortAWriteEnable;
   assign b_rd   = acc_ok & PortBEnable;

   // ---------------------------------------------------------------------
   // Array access
   // ---------------------------------------------------------------------
   logic [DATAWIDTH-1:0] a_old_word;
   logic [DATAWIDTH-1:0] a_merged;
   logic [DATAWIDTH-1:0] b_word;

   assign a_old_word = mem_q[PortAAddr];

   // Word as it will look after port A's masked write.
   always_comb begin
      a_merged = a_old_word;
      for (int i = 0; i < NBYTES; i++) begin
         if (PortAByteEnable[i]) begin
            a_merged[i*8 +: 8] = PortADataIn[i*8 +: 8];
         end
      end
   end

   // Port B bypasses the merged word on a same-address collision only in
   // read-new mode; read-old mode simply sees the array before the edge.
   always_comb begin
      b_word = mem_q[PortBAddr];
      if ((WRITEFIRST == COLL_READ_NEW) && a_wr && (PortAAddr == PortBAddr)) begin
         b_word = a_merged;
      end
   end

   // Clear and port A writes never coincide: InitBusy blocks port A.
   always_ff @(posedge RamClk) begin
      if (clr_we) begin
         mem_q[clr_addr] <= '0;
      end else if (a_wr) begin
         mem_q[PortAAddr] <= a_merged;
      end
   end

   // ---------------------------------------------------------------------
   // Read output pipelines
   // ---------------------------------------------------------------------
   ram_rd_pipe #(
      .DW      (DATAWIDTH),
      .LATENCY (READLATENCY)
   ) u_rd_pipe_a (
      .clk_i   (RamClk),
      .rst_i   (RamReset),
      .req_i   (a_rd),
      .data_i  (a_old_word),
      .data_o  (PortADataOut),
      .valid_o (PortAValid)
   );

   ram_rd_pipe #(
      .DW      (DATAWIDTH),
      .LATENCY (READLATENCY)
   ) u_rd_pipe_b (
      .clk_i   (RamClk),
      .rst_i   (RamReset),
      .req_i   (b_rd),
      .data_i  (b_word),
      .data_o  (PortBDataOut),
      .valid_o (PortBValid)
   );

endmodule

// File: doc/ram_sdp_be.md
RAM_SDP_BE -- requirements
Module: ram_sdp_be

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32, word width in bits; it SHALL be a multiple of 8.
REQ-002 SHALL have parameter ADDRWIDTH, default 10, address width; MEMDEPTH = 2**ADDRWIDTH words.
REQ-003 SHALL have parameter READLATENCY, default 1, read latency in cycles; legal values are 1 and 2.
REQ-004 SHALL have parameter WRITEFIRST, default 0, collision mode: 0 = read-old, 1 = read-new.
REQ-005 SHALL have parameter INITCLEAR, default 1; 1 = zero all words after reset.
REQ-006 SHALL have one clock; reset is synchronous and active-high.
REQ-007 Ports SHALL be, clock and reset first:
- RamClk  in  1  clock
- RamReset  in  1  synchronous active-high reset
- InitBusy  out  1  clear sequence in progress
- PortAEnable  in  1  port A access request
- PortAWriteEnable  in  1  1 = write, 0 = read
- PortAAddr  in  ADDRWIDTH  port A address
- PortADataIn  in  DATAWIDTH  write data
- PortAByteEnable  in  DATAWIDTH/8  per-byte write mask
- PortADataOut  out  DATAWIDTH  port A read data
- PortAValid  out  1  port A read data valid
- PortBEnable  in  1  port B read request
- PortBAddr  in  ADDRWIDTH  port B address
- PortBDataOut  out  DATAWIDTH  port B read data
- PortBValid  out  1  port B read data valid

Function
REQ-008 An access SHALL be accepted only when Enable=1, InitBusy=0 and RamReset=0; any other request SHALL be dropped silently.
REQ-009 A port A write SHALL update byte i only where PortAByteEnable[i]=1; an all-zero mask SHALL leave memory unchanged.
REQ-010 A port A write SHALL NOT change PortADataOut and SHALL NOT assert PortAValid.
REQ-011 A read accepted at edge N SHALL present its data on DataOut with Valid=1 after edge N+READLATENCY-1+1, i.e. READLATENCY cycles later.
REQ-012 Valid SHALL be a one-cycle pulse per accepted read; back-to-back reads SHALL give one result per cycle.
REQ-013 DataOut SHALL hold its last value when no new result is produced.
REQ-014 Collision (port B read and port A write to the same address in the same cycle):
- WRITEFIRST=0: PortBDataOut SHALL return the pre-write word.
- WRITEFIRST=1: PortBDataOut SHALL return the merged word (enabled bytes new, others old).
REQ-015 Accesses to different addresses on ports A and B SHALL be fully independent.
REQ-016 The clear FSM SHALL have states CLEAR and READY.
- RamReset=1 (INITCLEAR=1): state SHALL go to CLEAR with the counter at 0.
- In CLEAR: one word SHALL be written with 0 per cycle, counter incrementing; after word MEMDEPTH-1 the state SHALL go to READY.
REQ-017 InitBusy SHALL be 1 during reset and during CLEAR, and 0 in READY; the clear SHALL take exactly MEMDEPTH cycles after reset deassertion.
REQ-018 Reset asserted mid-clear SHALL restart the clear at address 0.
REQ-019 With INITCLEAR=0, InitBusy SHALL be constant 0; memory content after reset is undefined (X in simulation) and is unaffected by reset.
REQ-020 With INITCLEAR=1, reset SHALL NOT otherwise alter memory beyond the clear sequence.

Reset
REQ-021 On RamReset=1: PortADataOut=0, PortBDataOut=0, PortAValid=0, PortBValid=0, all read pipeline stages invalidated, and InitBusy=INITCLEAR.
REQ-022 A read in flight at reset SHALL be discarded and SHALL NOT produce Valid.

Structure
REQ-023 The collision-mode encoding, the clear-FSM state encoding and the READLATENCY range check SHALL live in the shared package ram_pkg.
REQ-024 The read output pipeline SHALL be one sub-module, ram_rd_pipe, instanced once per read port.
REQ-025 An illegal READLATENCY or DATAWIDTH SHALL cause an elaboration error.

Verification (DATAWIDTH=32, ADDRWIDTH=4, INITCLEAR=1 unless stated)
REQ-026 Bench SHALL cover the following directed scenarios:
- Release reset -> InitBusy=1 for exactly 16 cycles; then port B reads of addresses 0..15 all return 0x00000000.
- Write 0xAABBCCDD to addr 3, then write 0x11223344 with mask 4'b0101 -> read of addr 3 returns 0xAA22CC44, with Valid exactly READLATENCY cycles after the request (test READLATENCY=1 and 2).
- Collision: addr 5 holds 0x0; same cycle, A writes 0xFFFFFFFF with mask 4'b1111 and B reads addr 5 -> B returns 0x0 (WRITEFIRST=0) or 0xFFFFFFFF (WRITEFIRST=1).
- Reset asserted at clear counter=7, released 2 cycles later -> InitBusy=1 for a further 16 cycles; address 12, preloaded with a nonzero value, then reads 0.
- Request issued while InitBusy=1 (write 0x12345678 to addr 2) -> dropped; no Valid is produced and addr 2 later reads 0.
- Streaming port B reads of addrs 0..15 on consecutive cycles -> 16 consecutive Valid pulses with data in address order.
